// File: rtl/pic16_pkg.sv
// Shared constants for the PIC16 program-counter sequencer: default geometry and the
// instruction-field widths used to build page-relative addresses.
package pic16_pkg;

  localparam int unsigned PcWDefault       = 13;
  localparam int unsigned PclathWDefault   = 5;
  localparam int unsigned StkDepthDefault  = 8;
  localparam int unsigned RstVecDefault    = 0;

  // CALL/GOTO carry an 11-bit target; a PCL write supplies the low 8 bits.
  localparam int unsigned JaddrW = 11;
  localparam int unsigned PclW   = 8;

endpackage

// File: rtl/pic16_ret_stack.sv
// Circular hardware return stack: storage, write pointer, fill level and, with
// PC_STACK_ERR_EN defined, sticky overflow/underflow flags.
module pic16_ret_stack
  import pic16_pkg::*;
#(
  parameter int unsigned PcW   = PcWDefault,
  parameter int unsigned Depth = StkDepthDefault,
  localparam int unsigned SpW  = $clog2(Depth),
  localparam int unsigned LvlW = SpW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PcW-1:0]  wdata_i,
  output logic [PcW-1:0]  tos_o,
  output logic [LvlW-1:0] lvl_o
`ifdef PC_STACK_ERR_EN
  ,
  input  logic            err_clr_i,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            unf_o
`endif
);

  logic [PcW-1:0]  mem_q [Depth];
  logic [SpW-1:0]  sp_q, sp_d;
  logic [LvlW-1:0] lvl_q, lvl_d;
  logic            full, empty;

  assign full  = (lvl_q == LvlW'(Depth));
  assign empty = (lvl_q == '0);

  // Entries are not reset; a push always writes the slot at the pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i) begin
      mem_q[sp_q] <= wdata_i;
    end
  end

  assign tos_o = mem_q[sp_q - SpW'(1)];
  assign lvl_o = lvl_q;

`ifdef PC_STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic ovf_set, unf_set;
`endif

  always_comb begin
    sp_d  = sp_q;
    lvl_d = lvl_q;
`ifdef PC_STACK_ERR_EN
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (push_i) begin
      // Push wins over a simultaneous pop; a full stack wraps onto the oldest entry.
      sp_d = sp_q + SpW'(1);
      if (!full) begin
        lvl_d = lvl_q + LvlW'(1);
      end
`ifdef PC_STACK_ERR_EN
      ovf_set = full;
`endif
    end else if (pop_i) begin
`ifdef PC_STACK_ERR_EN
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_d  = sp_q - SpW'(1);
        lvl_d = lvl_q - LvlW'(1);
      end
`else
      sp_d = sp_q - SpW'(1);
      if (!empty) begin
        lvl_d = lvl_q - LvlW'(1);
      end
`endif
    end
  end

`ifdef PC_STACK_ERR_EN
  // A new error in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr_i) | ovf_set;
    unf_d = (unf_q & ~err_clr_i) | unf_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign empty_o = empty;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      lvl_q <= '0;
    end else begin
      sp_q  <= sp_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/pic16_pc_seq.sv
// PIC16 program-counter sequencer: PC next-state priority mux and fetch-squash REDIRECT.
// Define PC_STACK_ERR_EN to get sticky stack overflow/underflow flags and ERR_CLR.
module pic16_pc_seq
  import pic16_pkg::*;
#(
  parameter int unsigned PC_W      = PcWDefault,
  parameter int unsigned PCLATH_W  = PclathWDefault,
  parameter int unsigned STK_DEPTH = StkDepthDefault,
  parameter int unsigned RST_VEC   = RstVecDefault,
  localparam int unsigned LvlW     = $clog2(STK_DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                HOLD,
  input  logic                JMP,
  input  logic [JaddrW-1:0]   JADDR,
  input  logic                PUSH,
  input  logic                POP,
  input  logic                PCL_WE,
  input  logic [PclW-1:0]     PCL_D,
  input  logic [PCLATH_W-1:0] PCLATH,
  output logic [PC_W-1:0]     PC,
  output logic                REDIRECT,
  output logic [LvlW-1:0]     STK_LVL
`ifdef PC_STACK_ERR_EN
  ,
  input  logic                ERR_CLR,
  output logic                STK_OVF,
  output logic                STK_UNF
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tos;
  logic [PC_W-1:0] pop_addr;

`ifdef PC_STACK_ERR_EN
  logic stk_empty;
`endif

  pic16_ret_stack #(
    .PcW   (PC_W),
    .Depth (STK_DEPTH)
  ) u_ret_stack (
    .clk_i     (CLK),
    .rst_i     (RST),
    .push_i    (PUSH),
    .pop_i     (POP),
    .wdata_i   (pc_q),
    .tos_o     (tos),
    .lvl_o     (STK_LVL)
`ifdef PC_STACK_ERR_EN
    ,
    .err_clr_i (ERR_CLR),
    .empty_o   (stk_empty),
    .ovf_o     (STK_OVF),
    .unf_o     (STK_UNF)
`endif
  );

`ifdef PC_STACK_ERR_EN
  // An empty pop restarts at the reset vector rather than returning a stale entry.
  // A simultaneous push makes the pop a non-event for the stack but PC still follows tos.
  assign pop_addr = (stk_empty && !PUSH) ? PC_W'(RST_VEC) : tos;
`else
  assign pop_addr = tos;
`endif

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (JMP) begin
      pc_d = {PCLATH[PCLATH_W-1 -: PC_W-JaddrW], JADDR};
    end else if (PCL_WE) begin
      pc_d = {PCLATH[PC_W-PclW-1:0], PCL_D};
    end else if (POP) begin
      pc_d = pop_addr;
    end else if (HOLD) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= PC_W'(RST_VEC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC       = pc_q;
  assign REDIRECT = JMP | PCL_WE | POP;

endmodule

// File: tb/tb_pic16_pc_seq.sv
// Directed bench for pic16_pc_seq with a PC/level scoreboard; flag checks follow
// PC_STACK_ERR_EN.
module tb_pic16_pc_seq;

  logic        CLK = 1'b0;
  logic        RST, HOLD, JMP, PUSH, POP, PCL_WE;
  logic [10:0] JADDR;
  logic [7:0]  PCL_D;
  logic [4:0]  PCLATH;
  logic [12:0] PC;
  logic        REDIRECT;
  logic [3:0]  STK_LVL;
`ifdef PC_STACK_ERR_EN
  logic        ERR_CLR, STK_OVF, STK_UNF;
`endif

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_pc_q  [$];
  logic [3:0]  exp_lvl_q [$];

  always #5 CLK = ~CLK;

  pic16_pc_seq #(
    .PC_W      (13),
    .PCLATH_W  (5),
    .STK_DEPTH (8),
    .RST_VEC   (0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .HOLD     (HOLD),
    .JMP      (JMP),
    .JADDR    (JADDR),
    .PUSH     (PUSH),
    .POP      (POP),
    .PCL_WE   (PCL_WE),
    .PCL_D    (PCL_D),
    .PCLATH   (PCLATH),
    .PC       (PC),
    .REDIRECT (REDIRECT),
    .STK_LVL  (STK_LVL)
`ifdef PC_STACK_ERR_EN
    ,
    .ERR_CLR  (ERR_CLR),
    .STK_OVF  (STK_OVF),
    .STK_UNF  (STK_UNF)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    RST = 1'b0; HOLD = 1'b0; JMP = 1'b0; PUSH = 1'b0; POP = 1'b0; PCL_WE = 1'b0;
`ifdef PC_STACK_ERR_EN
    ERR_CLR = 1'b0;
`endif
  endtask

  // Queue the expected post-edge state, clock once, then compare against the queue head.
  task automatic tick(input string tag, input logic [12:0] epc, input logic [3:0] elvl);
    logic [12:0] p;
    logic [3:0]  l;
    exp_pc_q.push_back(epc);
    exp_lvl_q.push_back(elvl);
    @(posedge CLK);
    #1;
    clear_strobes();
    p = exp_pc_q.pop_front();
    l = exp_lvl_q.pop_front();
    chk({tag, ".pc"}, {3'b0, PC}, {3'b0, p});
    chk({tag, ".lvl"}, {12'b0, STK_LVL}, {12'b0, l});
  endtask

  task automatic chk_redirect(input string tag, input logic exp);
    #1;
    chk({tag, ".redirect"}, {15'b0, REDIRECT}, {15'b0, exp});
  endtask

  initial begin
    clear_strobes();
    JADDR = '0; PCL_D = '0; PCLATH = '0;
    @(negedge CLK);

    // Reset, then free-run.
    RST = 1'b1;
    tick("rst", 13'h000, 4'd0);
    tick("inc1", 13'h001, 4'd0);
    tick("inc2", 13'h002, 4'd0);
    tick("inc3", 13'h003, 4'd0);
    tick("inc4", 13'h004, 4'd0);
    tick("inc5", 13'h005, 4'd0);

    // CALL from 0x005, then return.
    PCLATH = 5'h18; JADDR = 11'h123; JMP = 1'b1; PUSH = 1'b1;
    chk_redirect("call", 1'b1);
    tick("call", 13'h1923, 4'd1);
    tick("callinc", 13'h1924, 4'd1);
    POP = 1'b1;
    chk_redirect("ret", 1'b1);
    tick("ret", 13'h005, 4'd0);

    // Computed goto, then JMP beating PCL_WE.
    PCLATH = 5'h03; PCL_D = 8'h40; PCL_WE = 1'b1;
    tick("pclwe", 13'h0340, 4'd0);
    PCL_WE = 1'b1; JMP = 1'b1; JADDR = 11'h010;
    tick("jmpwin", 13'h010, 4'd0);

    // Sleep hold.
    HOLD = 1'b1;
    chk_redirect("hold", 1'b0);
    for (int i = 0; i < 4; i++) begin
      HOLD = 1'b1;
      tick("hold", 13'h010, 4'd0);
    end
    tick("unhold", 13'h011, 4'd0);

    // PC wraps at 2^13.
    PCLATH = 5'h18; JADDR = 11'h7FF; JMP = 1'b1;
    tick("jmptop", 13'h1FFF, 4'd0);
    tick("wrap", 13'h0000, 4'd0);

    // Nine pushes at depth 8 from PCs 1..9, then eight pops.
    RST = 1'b1;
    tick("rst2", 13'h000, 4'd0);
    tick("pre", 13'h001, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      PUSH = 1'b1;
      tick("push", 13'(i + 1), (i > 8) ? 4'd8 : 4'(i));
    end
`ifdef PC_STACK_ERR_EN
    chk("ovf", {15'b0, STK_OVF}, 16'd1);
    chk("unf0", {15'b0, STK_UNF}, 16'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      POP = 1'b1;
      tick("pop", 13'(9 - i), 4'(7 - i));
    end

    // Pop at empty.
    POP = 1'b1;
`ifdef PC_STACK_ERR_EN
    tick("popempty", 13'h000, 4'd0);
    chk("unf", {15'b0, STK_UNF}, 16'd1);
    ERR_CLR = 1'b1;
    tick("errclr", 13'h001, 4'd0);
    chk("unfclr", {15'b0, STK_UNF}, 16'd0);
    chk("ovfclr", {15'b0, STK_OVF}, 16'd0);
`else
    tick("popempty", 13'h009, 4'd0);
    tick("afterpop", 13'h00A, 4'd0);
`endif

    // Reset overrides a push; hold does not block a push; push wins over pop for the stack.
    RST = 1'b1; PUSH = 1'b1;
    tick("rstpush", 13'h000, 4'd0);
    tick("pre3", 13'h001, 4'd0);
    HOLD = 1'b1; PUSH = 1'b1;
    tick("holdpush", 13'h001, 4'd1);
    tick("inc", 13'h002, 4'd1);
    PUSH = 1'b1; POP = 1'b1;
    tick("pushpop", 13'h001, 4'd2);
    POP = 1'b1;
    tick("pop2", 13'h002, 4'd1);
    POP = 1'b1;
    tick("pop1", 13'h001, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic16_pc_seq.md
# pic16_pc_seq

Parametrised program-counter sequencer with hardware return stack for the PIC16-family core. It replaces the inline PC and return-stack logic. It adds configurable PC width and stack depth, and stores full-width return addresses. It also provides a stack fill level and optional sticky overflow/underflow detection. The sequencer sits between the instruction decoder, which drives the control strobes, and instruction memory, which is addressed by `PC`.

## Interface
- `PC_W`, 13: program counter width; must satisfy 11 < `PC_W` ≤ 8 + `PCLATH_W`.
- `PCLATH_W`, 5: width of the PCLATH input.
- `STK_DEPTH`, 8: return-stack entries; power of two, ≥ 2.
- `RST_VEC`, 0: PC value after reset.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `HOLD` in 1: sleep hold; PC does not advance.
- `JMP` in 1: CALL/GOTO redirect.
- `JADDR` in 11: instruction address field (IR[10:0]).
- `PUSH` in 1: push the return address (CALL).
- `POP` in 1: pop the return address (RETURN/RETLW).
- `PCL_WE` in 1: data write to PCL (computed goto).
- `PCL_D` in 8: PCL write data.
- `PCLATH` in `PCLATH_W`: current PCLATH register.
- `PC` out `PC_W`: fetch address, registered.
- `REDIRECT` out 1: combinational OR of `JMP`, `PCL_WE` and `POP`; the decoder uses it to squash the fetched word.
- `STK_LVL` out clog2(`STK_DEPTH`)+1: entries in use, registered.
- `STK_OVF` out 1: sticky overflow (only with the `PC_STACK_ERR_EN` macro).
- `STK_UNF` out 1: sticky underflow (only with the `PC_STACK_ERR_EN` macro).
- `ERR_CLR` in 1: clears `STK_OVF`/`STK_UNF` (only with the `PC_STACK_ERR_EN` macro).

## Operation
- PC next-state priority, highest first:
  1. `RST` → `RST_VEC`.
  2. `JMP` → {`PCLATH`[`PCLATH_W`-1 -: `PC_W`-11], `JADDR`}.
  3. `PCL_WE` → {`PCLATH`[`PC_W`-9:0], `PCL_D`}.
  4. `POP` → top-of-stack.
  5. `HOLD` → PC unchanged.
  6. Otherwise → PC+1, wrapping modulo 2^`PC_W`.
- Stack storage and pointer:
  - Circular buffer of `STK_DEPTH` × `PC_W` bits.
  - Write pointer `SP` of log2(`STK_DEPTH`) bits.
  - Top-of-stack = entry[`SP`-1], read combinationally.
- Push (`PUSH`=1):
  - entry[`SP`] ← current `PC` (already the address of the next instruction).
  - `SP` ← `SP`+1.
  - `STK_LVL` ← min(`STK_LVL`+1, `STK_DEPTH`).
- Pop (`POP`=1, `PUSH`=0):
  - `SP` ← `SP`-1.
  - `STK_LVL` ← max(`STK_LVL`-1, 0).
- `PUSH` and `POP` in the same cycle: the push is performed and the pop is ignored for stack state. PC still follows the priority list above.
- Stack actions are independent of `HOLD`. A push or pop while `HOLD` is asserted still executes.
- `RST` clears `SP`, `STK_LVL`, `STK_OVF` and `STK_UNF`. Entry contents are not reset.
- Reset mid-operation: `RST` overrides every strobe in the same cycle; no push or pop takes effect.

## Timing
- Every strobe takes effect at the next rising edge; `PC` and `STK_LVL` show the result one cycle later.
- `REDIRECT` is combinational, with zero latency relative to the strobes.
- Reset values: `PC`=`RST_VEC`, `STK_LVL`=0, `STK_OVF`=0, `STK_UNF`=0.
- Back-to-back CALL then RETURN:
  - The pop in cycle n+1 sees the entry written in cycle n.
  - The stack write is visible at the next edge, so no bypass is needed.

## Configuration
- `PC_STACK_ERR_EN` defined:
  - A push with `STK_LVL`=`STK_DEPTH` still wraps and overwrites the oldest entry, and sets `STK_OVF`.
  - A pop with `STK_LVL`=0 loads PC with `RST_VEC` instead of a stale entry, leaves `SP` unchanged, and sets `STK_UNF`.
  - The flags hold until `ERR_CLR` or `RST`.
  - `ERR_CLR` and a new error in the same cycle: the flag is set.
- `PC_STACK_ERR_EN` undefined:
  - Silent PIC16 behaviour; push wraps and pop at empty returns the entry at `SP`-1 with `SP` wrapping.
  - `STK_OVF`, `STK_UNF` and `ERR_CLR` ports are absent.

## Structure
- Shared package `pic16_pkg` holds:
  - the default `PC_W`, `PCLATH_W`, `STK_DEPTH` and `RST_VEC` constants;
  - the page-select slice widths (11-bit jump field, 8-bit PCL).
- Sub-module `pic16_ret_stack` is the circular LIFO. It owns storage, `SP`, level and, under the macro, the error flags.
- The top level holds only PC next-state muxing and `REDIRECT`.

## Test plan
- Reset then 3 idle cycles → `PC` = 0,1,2,3; `STK_LVL`=0.
- `PC`=0x005 with `PCLATH`=0x18, `JMP`+`PUSH`, `JADDR`=0x123 → `PC`=0x1923, `STK_LVL`=1. A later `POP` → `PC`=0x005, `STK_LVL`=0.
- `PCL_WE`, `PCL_D`=0x40, `PCLATH`=0x03 → `PC`=0x0340. With `JMP` in the same cycle, `JMP` wins.
- `HOLD`=1 for 4 cycles at `PC`=0x010 → `PC` stays 0x010; releasing `HOLD` → 0x011.
- 9 pushes at `STK_DEPTH`=8 (PCs 1..9), then 8 pops:
  - returns are 9,8,…,2 and `STK_LVL` saturates at 8;
  - with the macro, `STK_OVF`=1.
- Macro on: `POP` at `STK_LVL`=0 → `PC`=`RST_VEC`, `STK_UNF`=1; `ERR_CLR` → `STK_UNF`=0 the next cycle.
